// File: rtl/clk_gen_ctrl.sv
// clk_gen_ctrl: programmable clock-pulse generator controller.
// Produces gen_clk from a period / high-time / start-phase triple, all counted
// in reference-clock cycles. Configuration arrives over a valid/ready handshake.
// While the generator runs, a new config is parked in a shadow register. It is
// applied only at the LOW->HIGH period boundary, so the waveform never glitches.

`timescale 1ns/1ps

module clk_gen_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             gen_clk,
  output logic             period_tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  // A config is usable when period >= 2 and 1 <= high <= period-1.
  // The low time is therefore never zero and never wraps.
  function automatic logic cfg_legal(input logic [CNT_W-1:0] period,
                                     input logic [CNT_W-1:0] high);
    logic ok;
    ok = (period >= CNT_W'(2)) && (high >= CNT_W'(1)) &&
         (high <= (period - CNT_W'(1)));
    return ok;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] act_period_r;
  logic [CNT_W-1:0] act_high_r;
  logic [CNT_W-1:0] act_phase_r;
  logic [CNT_W-1:0] pend_period_r;
  logic [CNT_W-1:0] pend_high_r;
  logic             pend_valid_r;
  logic             gen_clk_r;
  logic             period_tick_r;
  logic             cfg_err_r;
  logic             busy_r;

  logic             accept_s;
  logic             cfg_good_s;
  logic [CNT_W-1:0] eff_high_s;
  logic [CNT_W-1:0] eff_phase_s;

  assign cfg_ready   = ~pend_valid_r;
  assign gen_clk     = gen_clk_r;
  assign period_tick = period_tick_r;
  assign cfg_err     = cfg_err_r;
  assign busy        = busy_r;

  // Handshake decode and start-time config selection. A legal config accepted
  // in IDLE on the start edge is used immediately, including its phase.
  always_comb begin
    accept_s    = cfg_valid & ~pend_valid_r;
    cfg_good_s  = cfg_legal(cfg_period, cfg_high);
    eff_high_s  = act_high_r;
    eff_phase_s = act_phase_r;
    if (accept_s && cfg_good_s && (state_r == ST_IDLE)) begin
      eff_high_s  = cfg_high;
      eff_phase_s = cfg_phase;
    end else begin
      eff_high_s  = act_high_r;
      eff_phase_s = act_phase_r;
    end
  end

  // Config registers, waveform state machine and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      act_period_r  <= CNT_W'(2);
      act_high_r    <= CNT_W'(1);
      act_phase_r   <= {CNT_W{1'b0}};
      pend_period_r <= {CNT_W{1'b0}};
      pend_high_r   <= {CNT_W{1'b0}};
      pend_valid_r  <= 1'b0;
      gen_clk_r     <= 1'b0;
      period_tick_r <= 1'b0;
      cfg_err_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      cfg_err_r     <= accept_s & ~cfg_good_s;
      period_tick_r <= 1'b0;

      // Store an accepted legal config: active when idle, shadow when running.
      if (accept_s && cfg_good_s) begin
        if (state_r == ST_IDLE) begin
          act_period_r <= cfg_period;
          act_high_r   <= cfg_high;
          act_phase_r  <= cfg_phase;
        end else begin
          pend_period_r <= cfg_period;
          pend_high_r   <= cfg_high;
          pend_valid_r  <= 1'b1;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (start && !stop) begin
            busy_r <= 1'b1;
            if (eff_phase_s == {CNT_W{1'b0}}) begin
              state_r       <= ST_HIGH;
              cnt_r         <= eff_high_s - CNT_W'(1);
              gen_clk_r     <= 1'b1;
              period_tick_r <= 1'b1;
            end else begin
              state_r <= ST_PHASE;
              cnt_r   <= eff_phase_s - CNT_W'(1);
            end
          end
        end
        ST_PHASE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r       <= ST_HIGH;
            cnt_r         <= act_high_r - CNT_W'(1);
            gen_clk_r     <= 1'b1;
            period_tick_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r   <= ST_LOW;
            cnt_r     <= act_period_r - act_high_r - CNT_W'(1);
            gen_clk_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r       <= ST_HIGH;
            gen_clk_r     <= 1'b1;
            period_tick_r <= 1'b1;
            if (pend_valid_r) begin
              act_period_r <= pend_period_r;
              act_high_r   <= pend_high_r;
              pend_valid_r <= 1'b0;
              cnt_r        <= pend_high_r - CNT_W'(1);
            end else begin
              cnt_r <= act_high_r - CNT_W'(1);
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          gen_clk_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase

      // Stop has priority over everything else while running; it truncates the
      // waveform and discards any parked config.
      if (stop && (state_r != ST_IDLE)) begin
        state_r       <= ST_IDLE;
        gen_clk_r     <= 1'b0;
        period_tick_r <= 1'b0;
        busy_r        <= 1'b0;
        pend_valid_r  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// tb_clk_gen_ctrl: directed self-checking bench for clk_gen_ctrl.
// Each cycle compares the vector {gen_clk, period_tick, busy, cfg_ready, cfg_err}
// against hand-derived expectations. Sampling and driving happen on the falling edge.

`timescale 1ns/1ps

module tb_clk_gen_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_err;
  logic             start;
  logic             stop;
  logic             gen_clk;
  logic             period_tick;
  logic             busy;
  logic [4:0]       obs;

  int n_cmp = 0;
  int n_bad = 0;

  clk_gen_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .start(start), .stop(stop), .gen_clk(gen_clk),
    .period_tick(period_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {gen_clk, period_tick, busy, cfg_ready, cfg_err};

  task automatic test_reset();
    logic [4:0] exp_v;
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_v = 5'b00010;
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset got %b want %b", obs, exp_v); end
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_hold got %b want %b", obs, exp_v); end
  endtask

  task automatic test_basic_wave();
    logic [4:0] exp_v;
    cfg_valid = 1'b1; cfg_period = 16'd10; cfg_high = 16'd3; cfg_phase = 16'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    exp_v = 5'b00010;
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL basic_cfg got %b want %b", obs, exp_v); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 25; j++) begin
      exp_v = {((j % 10) < 3), ((j % 10) == 0), 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL basic_wave j=%0d got %b want %b", j, obs, exp_v); end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    exp_v = 5'b00010;
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL basic_stop got %b want %b", obs, exp_v); end
  endtask

  task automatic test_phase();
    logic [4:0] exp_v;
    int k;
    cfg_valid = 1'b1; cfg_period = 16'd6; cfg_high = 16'd2; cfg_phase = 16'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 17; j++) begin
      k = j - 4;
      if (j < 4) exp_v = 5'b00110;
      else exp_v = {((k % 6) < 2), ((k % 6) == 0), 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL phase_wave j=%0d got %b want %b", j, obs, exp_v); end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_invalid_cfg();
    logic [4:0]       exp_v;
    logic [CNT_W-1:0] bad_p [3];
    logic [CNT_W-1:0] bad_h [3];
    bad_p[0] = 16'd10; bad_h[0] = 16'd0;
    bad_p[1] = 16'd10; bad_h[1] = 16'd10;
    bad_p[2] = 16'd1;  bad_h[2] = 16'd1;
    cfg_valid = 1'b1; cfg_period = 16'd10; cfg_high = 16'd3; cfg_phase = 16'd0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_period = bad_p[i]; cfg_high = bad_h[i]; cfg_phase = 16'd7;
      @(negedge clk);
      cfg_valid = 1'b0;
      exp_v = 5'b00011;
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL invalid_err i=%0d got %b want %b", i, obs, exp_v); end
      @(negedge clk);
      exp_v = 5'b00010;
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL invalid_clear i=%0d got %b want %b", i, obs, exp_v); end
    end
    // Invalid config on the start edge: old 3/7 config must be used.
    cfg_valid = 1'b1; cfg_period = 16'd1; cfg_high = 16'd0; cfg_phase = 16'd5;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      exp_v = {((j % 10) < 3), ((j % 10) == 0), 1'b1, 1'b1, (j == 0)};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL invalid_wave j=%0d got %b want %b", j, obs, exp_v); end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_shadow_update();
    logic [4:0] exp_v;
    logic       exp_rdy;
    int k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 23; j++) begin
      exp_rdy = (j <= 4) || (j >= 10);
      k = j - 10;
      if (j < 10) exp_v = {(j < 3), (j == 0), 1'b1, exp_rdy, 1'b0};
      else exp_v = {((k % 4) < 2), ((k % 4) == 0), 1'b1, exp_rdy, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL shadow_wave j=%0d got %b want %b", j, obs, exp_v); end
      if (j == 4) begin
        cfg_valid = 1'b1; cfg_period = 16'd4; cfg_high = 16'd2; cfg_phase = 16'd0;
      end
      if (j == 5) begin
        cfg_period = 16'd8; cfg_high = 16'd4;
      end
      if (j == 9) cfg_valid = 1'b0;
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_stop_restart();
    logic [4:0] exp_v;
    int k;
    cfg_valid = 1'b1; cfg_period = 16'd10; cfg_high = 16'd3; cfg_phase = 16'd2;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp_v = {(j >= 2), (j == 2), 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL stop_pre j=%0d got %b want %b", j, obs, exp_v); end
      if (j == 3) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    exp_v = 5'b00010;
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL stop_trunc got %b want %b", obs, exp_v); end
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL stop_idle got %b want %b", obs, exp_v); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 13; j++) begin
      k = j - 2;
      if (j < 2) exp_v = 5'b00110;
      else exp_v = {((k % 10) < 3), ((k % 10) == 0), 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL restart_wave j=%0d got %b want %b", j, obs, exp_v); end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] exp_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      exp_v = {(j >= 2) && (j < 5), (j == 2), 1'b1, (j <= 6), 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_rst j=%0d got %b want %b", j, obs, exp_v); end
      if (j == 6) begin
        cfg_valid = 1'b1; cfg_period = 16'd4; cfg_high = 16'd2; cfg_phase = 16'd0;
      end
      if (j == 7) begin
        cfg_valid = 1'b0; rst = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    exp_v = 5'b00010;
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL mid_rst got %b want %b", obs, exp_v); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      exp_v = {((j % 2) == 0), ((j % 2) == 0), 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL default_wave j=%0d got %b want %b", j, obs, exp_v); end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    exp_v = 5'b00010;
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL start_stop got %b want %b", obs, exp_v); end
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL start_stop_hold got %b want %b", obs, exp_v); end
  endtask

  task automatic test_edge_high();
    logic [4:0] exp_v;
    cfg_valid = 1'b1; cfg_period = 16'd3; cfg_high = 16'd2; cfg_phase = 16'd0;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    for (int j = 0; j < 9; j++) begin
      exp_v = {((j % 3) < 2), ((j % 3) == 0), 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL edge_high j=%0d got %b want %b", j, obs, exp_v); end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_wave();
    test_phase();
    test_invalid_cfg();
    test_shadow_update();
    test_stop_restart();
    test_reset_mid_run();
    test_edge_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_gen_ctrl.md
Name: clk_gen_ctrl

Overview:
Synthesizable programmable clock-pulse generator controller running off a single reference clock.
- Sequences an output waveform `gen_clk` from programmed period, high-time and start-phase values, all counted in reference-clock cycles.
- Configuration is taken over a valid/ready handshake. Changes made while running are double-buffered and take effect only at a period boundary, so no glitch is produced.
- Sits between the configuration/control logic and any block needing a derived clock enable or strobe.

Parameters:
- CNT_W, 16: width of the period, high-time and phase fields and of the internal counters.

Ports:
- clk  in  1  reference clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration can be accepted this cycle
- cfg_period  in  CNT_W  period in cycles
- cfg_high  in  CNT_W  high time in cycles
- cfg_phase  in  CNT_W  delay from start to first rising edge, in cycles
- cfg_err  out  1  one-cycle pulse: handshaken config was rejected
- start  in  1  begin generation (level-sampled)
- stop  in  1  halt generation (level-sampled)
- gen_clk  out  1  generated waveform, registered
- period_tick  out  1  one-cycle pulse on the first high cycle of every period
- busy  out  1  generator running (state != IDLE)

Behaviour:
Reset:
- `gen_clk`=0, `period_tick`=0, `cfg_err`=0, `busy`=0, `cfg_ready`=1.
- Active config = period 2, high 1, phase 0.
- Pending shadow cleared; state IDLE.
- `rst` asserted mid-operation has the same effect in the following cycle; any pending config is discarded.

Config handshake:
- A config is accepted on an edge where `cfg_valid` && `cfg_ready`.
- Valid iff `cfg_period` >= 2 and 1 <= `cfg_high` <= `cfg_period`-1. `cfg_phase` is unrestricted.
- Invalid config: still handshaken, not stored; `cfg_err`=1 for exactly the next cycle.
- In IDLE a valid config writes the active registers directly.
- While busy a valid config goes to the pending shadow, and `cfg_ready` drops to 0 until the shadow is applied.
- `cfg_ready` = !pending.

State machine (IDLE, PHASE, HIGH, LOW), one down-counter:
- IDLE: `start` sampled at edge E0 (and no `stop`):
  - phase P=0: go to HIGH.
  - P>0: go to PHASE for P cycles, then HIGH.
  - `gen_clk` first reads 1 in the cycle after edge E0+P.
- HIGH: `gen_clk`=1 for exactly `high` cycles, then LOW.
- LOW: `gen_clk`=0 for exactly `period`-`high` cycles, then HIGH.
- Period boundary = LOW->HIGH transition. If the pending shadow was already set before the boundary edge, period/high load from the shadow at that edge and pending clears. A config accepted on the boundary edge itself waits for the next boundary.
- Shadow phase is ignored while running; phase applies only on `start`.
- `period_tick`=1 in the first HIGH cycle of each period, including the first after start.
- `start` while busy is ignored.

Stop and simultaneous events:
- `stop` sampled in any non-IDLE state: next cycle state IDLE, `gen_clk`=0 (a HIGH pulse is truncated), pending discarded.
- `start` and `stop` together: `stop` wins.
- Config accepted in IDLE on the same edge as `start`: generation uses the newly accepted config, including its phase.
- Invalid config on the same edge as `start`: start uses the old active config.

Arithmetic:
- Counters are CNT_W bits, load value-1 and count down to 0. Overflow is impossible by the validity rules.
- Full-scale period 2^CNT_W-1 is supported.

Test Plan:
1. Reset; cfg period=10, high=3, phase=0; `start` -> `gen_clk` 3 high / 7 low repeating, `period_tick` every 10 cycles aligned to each rise, `busy`=1.
2. cfg phase=4, period=6, high=2; `start` at edge E0 -> `gen_clk` first 1 after edge E0+4, then 2/4 pattern.
3. Invalid cfgs (high=0; high=10 with period=10; period=1) -> each gives a 1-cycle `cfg_err`; a following `start` shows the prior 3/7 waveform unchanged.
4. Running 3/7; in LOW accept period=4, high=2 -> `cfg_ready`=0; the current period finishes 7 low, then 2/2 from the next boundary; `cfg_ready` returns to 1 after that boundary; a second `cfg_valid` during the pending window is not accepted.
5. `stop` in the 2nd HIGH cycle -> `gen_clk`=0 and `busy`=0 next cycle; re-`start` honours the phase again.
6. `rst` mid-LOW with pending set -> all outputs at reset values, period 2/high 1 restored; `start`+`stop` in the same IDLE cycle -> stays IDLE, `gen_clk`=0.
